// File: rtl/tone_pkg.sv
// Shared encodings and types for the tone sequencer.
package tone_pkg;

    localparam int unsigned LANE_W     = 2;
    localparam int unsigned HALF_W     = 7;
    localparam int unsigned NOTE_DUR_W = 16;

    localparam logic [LANE_W-1:0] LANE_F4   = 2'd0;
    localparam logic [LANE_W-1:0] LANE_G4   = 2'd1;
    localparam logic [LANE_W-1:0] LANE_B4   = 2'd2;
    localparam logic [LANE_W-1:0] LANE_REST = 2'd3;

    // Half-period minus one, in audio samples (48 kHz sample rate).
    localparam logic [HALF_W-1:0] HALF_F4 = 7'd68;
    localparam logic [HALF_W-1:0] HALF_G4 = 7'd61;
    localparam logic [HALF_W-1:0] HALF_B4 = 7'd48;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Note event at the default duration width.
    typedef struct packed {
        logic [LANE_W-1:0]     lane;
        logic [NOTE_DUR_W-1:0] dur;
    } note_t;

    // Half-period limit for a lane; rests never toggle so their value is unused.
    function automatic logic [HALF_W-1:0] half_lim_of(input logic [LANE_W-1:0] lane);
        logic [HALF_W-1:0] lim;
        case (lane)
            LANE_F4: lim = HALF_F4;
            LANE_G4: lim = HALF_G4;
            LANE_B4: lim = HALF_B4;
            default: lim = '0;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Small pointer+count FIFO holding queued note events.
module note_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned W     = 18,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wr_data,
    output logic [W-1:0]     rd_data_c,
    output logic [CNT_W-1:0] count_c,
    output logic             full_c,
    output logic             empty_c
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_c    = (count_q == CNT_W'(DEPTH));
    assign empty_c   = (count_q == '0);
    assign count_c   = count_q;
    assign rd_data_c = mem[rd_ptr_q];

    // Pointer and occupancy update; a full FIFO refuses even with a concurrent pop.
    always_comb begin
        do_push  = push && !full_c && !clr;
        do_pop   = pop && !empty_c && !clr;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/tone_sequencer.sv
// Plays queued note events as square-wave samples into the audio write port.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DUR_W = 16,
    parameter int unsigned GAP   = 240,
    parameter logic [31:0] AMP   = 32'h7F000000
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             flush,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [1:0]       note_lane,
    input  logic [DUR_W-1:0] note_dur,
    input  logic             audio_out_allowed,
    output logic             write_audio_out,
    output logic [31:0]      left_channel_audio_out,
    output logic [31:0]      right_channel_audio_out,
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [DUR_W-1:0] GAP_INIT = DUR_W'(GAP);
    localparam logic [31:0]      NEG_AMP  = ~AMP + 32'd1;

    typedef struct packed {
        logic [LANE_W-1:0] lane;
        logic [DUR_W-1:0]  dur;
    } note_w_t;

    note_w_t          push_note, head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;

    state_e            state_q, state_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic [HALF_W-1:0] half_lim_q, half_lim_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              snd_q, snd_d;
    logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
    logic [DUR_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [31:0]       data_q, data_d;
    state_e            after_note;

    assign push_note  = '{lane: note_lane, dur: note_dur};
    assign note_ready = !fifo_full && !flush;
    assign fifo_push  = note_valid && note_ready;
    assign fifo_pop   = (state_q == ST_LOAD) && !flush;

    assign write_audio_out         = ((state_q == ST_PLAY) || (state_q == ST_GAP)) && audio_out_allowed;
    assign left_channel_audio_out  = data_q;
    assign right_channel_audio_out = data_q;
    assign busy                    = (state_q != ST_IDLE) || !fifo_empty;

    note_fifo #(
        .DEPTH (DEPTH),
        .W     (LANE_W + DUR_W)
    ) u_fifo (
        .clk       (CLOCK_50),
        .rst_n     (resetn),
        .clr       (flush),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .wr_data   (push_note),
        .rd_data_c (head),
        .count_c   (fifo_count),
        .full_c    (fifo_full),
        .empty_c   (fifo_empty)
    );

    // Sequencing FSM, sample/pitch counters and next sample value.
    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        half_lim_d = half_lim_q;
        lane_d     = lane_q;
        snd_d      = snd_q;
        dur_cnt_d  = dur_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        // A queued note skips the IDLE cycle so consecutive notes sit one LOAD apart.
        after_note = fifo_empty ? ST_IDLE : ST_LOAD;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                half_cnt_d = '0;
                snd_d      = 1'b0;
                dur_cnt_d  = head.dur;
                half_lim_d = half_lim_of(head.lane);
                lane_d     = head.lane;
                if (head.dur != '0) begin
                    state_d = ST_PLAY;
                end else if (GAP != 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_INIT;
                end else begin
                    // The head being popped is still counted here.
                    state_d = (fifo_count > CNT_W'(1)) ? ST_LOAD : ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (audio_out_allowed) begin
                    dur_cnt_d = dur_cnt_q - DUR_W'(1);
                    if (half_cnt_q == half_lim_q) begin
                        half_cnt_d = '0;
                        snd_d      = ~snd_q;
                    end else begin
                        half_cnt_d = half_cnt_q + HALF_W'(1);
                    end
                    if (dur_cnt_q == DUR_W'(1)) begin
                        if (GAP != 0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = GAP_INIT;
                        end else begin
                            state_d = after_note;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (audio_out_allowed) begin
                    gap_cnt_d = gap_cnt_q - DUR_W'(1);
                    if (gap_cnt_q == DUR_W'(1)) state_d = after_note;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d    = ST_IDLE;
            snd_d      = 1'b0;
            half_cnt_d = '0;
            dur_cnt_d  = '0;
            gap_cnt_d  = '0;
        end

        data_d = '0;
        if ((state_d == ST_PLAY) && (lane_d != LANE_REST)) data_d = snd_d ? AMP : NEG_AMP;
    end

    // State, counter and sample registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            half_cnt_q <= '0;
            half_lim_q <= '0;
            lane_q     <= '0;
            snd_q      <= 1'b0;
            dur_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            half_lim_q <= half_lim_d;
            lane_q     <= lane_d;
            snd_q      <= snd_d;
            dur_cnt_q  <= dur_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: one instance with GAP=0, one with GAP=3.
module tb_tone_sequencer;

    localparam logic [31:0] AMP  = 32'h7F000000;
    localparam logic [31:0] NAMP = 32'h81000000;
    localparam int          G3   = 3;

    logic        clk = 1'b0;
    logic        resetn, flush, note_valid, allowed;
    logic [1:0]  note_lane;
    logic [15:0] note_dur;

    logic        rdy0, wr0, busy0, rdy3, wr3, busy3;
    logic [31:0] l0, r0, l3, r3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] q0[$];
    logic [31:0] q3[$];
    logic [31:0] e0, e3;
    int nwr0, nwr3, first0, last0, first3, last3;

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    tone_sequencer #(.DEPTH(4), .DUR_W(16), .GAP(0), .AMP(AMP)) dut0 (
        .CLOCK_50(clk), .resetn(resetn), .flush(flush), .note_valid(note_valid),
        .note_ready(rdy0), .note_lane(note_lane), .note_dur(note_dur),
        .audio_out_allowed(allowed), .write_audio_out(wr0),
        .left_channel_audio_out(l0), .right_channel_audio_out(r0), .busy(busy0));

    tone_sequencer #(.DEPTH(4), .DUR_W(16), .GAP(G3), .AMP(AMP)) dut3 (
        .CLOCK_50(clk), .resetn(resetn), .flush(flush), .note_valid(note_valid),
        .note_ready(rdy3), .note_lane(note_lane), .note_dur(note_dur),
        .audio_out_allowed(allowed), .write_audio_out(wr3),
        .left_channel_audio_out(l3), .right_channel_audio_out(r3), .busy(busy3));

    // Compare every written sample of the GAP=0 instance against the scoreboard.
    always @(negedge clk) begin
        if (resetn && wr0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL dut0 unexpected write: data %h, expected no write", l0);
            end else begin
                e0 = q0.pop_front();
                if (l0 !== e0 || r0 !== e0) begin
                    errors++;
                    $display("FAIL dut0 sample %0d: left %h right %h, expected %h", nwr0 + 1, l0, r0, e0);
                end
            end
            if (nwr0 == 0) first0 = cyc;
            last0 = cyc;
            nwr0++;
        end
    end

    // Compare every written sample of the GAP=3 instance against the scoreboard.
    always @(negedge clk) begin
        if (resetn && wr3) begin
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL dut3 unexpected write: data %h, expected no write", l3);
            end else begin
                e3 = q3.pop_front();
                if (l3 !== e3 || r3 !== e3) begin
                    errors++;
                    $display("FAIL dut3 sample %0d: left %h right %h, expected %h", nwr3 + 1, l3, r3, e3);
                end
            end
            if (nwr3 == 0) first3 = cyc;
            last3 = cyc;
            nwr3++;
        end
    end

    function automatic logic [31:0] tone_sample(input logic [1:0] lane, input int k);
        int half;
        case (lane)
            2'd0:    half = 69;
            2'd1:    half = 62;
            2'd2:    half = 49;
            default: half = 0;
        endcase
        if (lane == 2'd3) return 32'h0;
        return ((((k - 1) / half) % 2) == 1) ? AMP : NAMP;
    endfunction

    task automatic model_push(input logic [1:0] lane, input int dur);
        for (int k = 1; k <= dur; k++) begin
            q0.push_back(tone_sample(lane, k));
            q3.push_back(tone_sample(lane, k));
        end
        for (int g = 0; g < G3; g++) q3.push_back(32'h0);
    endtask

    task automatic clear_counts();
        nwr0 = 0; nwr3 = 0; first0 = 0; last0 = 0; first3 = 0; last3 = 0;
    endtask

    // Offer one note (called at posedge+1), expecting it to be accepted.
    task automatic send(input logic [1:0] lane, input int dur);
        note_valid = 1'b1;
        note_lane  = lane;
        note_dur   = 16'(dur);
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1 || rdy3 !== 1'b1) begin
            errors++;
            $display("FAIL push_ready lane %0d: dut0 %b dut3 %b, expected 1", lane, rdy0, rdy3);
        end
        @(posedge clk);
        model_push(lane, dur);
        #1 note_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cyc);
        int i;
        i = 0;
        while ((q0.size() != 0 || q3.size() != 0 || busy0 || busy3) && i < max_cyc) begin
            @(posedge clk); #1;
            i++;
        end
        checks++;
        if (q0.size() != 0 || q3.size() != 0 || busy0 !== 1'b0 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL %s drain: pending %0d/%0d busy %b/%b, expected 0/0 and idle",
                     name, q0.size(), q3.size(), busy0, busy3);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({rdy0, wr0, busy0, l0, r0} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL %s dut0: ready %b write %b busy %b data %h/%h, expected 1 0 0 0/0",
                     name, rdy0, wr0, busy0, l0, r0);
        end
        checks++;
        if ({rdy3, wr3, busy3, l3, r3} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL %s dut3: ready %b write %b busy %b data %h/%h, expected 1 0 0 0/0",
                     name, rdy3, wr3, busy3, l3, r3);
        end
    endtask

    task automatic check_counts(input string name, input int exp0, input int exp3);
        checks++;
        if (nwr0 != exp0 || nwr3 != exp3) begin
            errors++;
            $display("FAIL %s write count: dut0 %0d dut3 %0d, expected %0d %0d", name, nwr0, nwr3, exp0, exp3);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; flush = 1'b0; note_valid = 1'b0; allowed = 1'b1;
        note_lane = 2'd0; note_dur = 16'd0;
        clear_counts();
        #5;
        check_idle_outputs("reset");
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_b4_tone();
        clear_counts();
        allowed = 1'b1;
        send(2'd2, 200);
        checks++;
        if (wr0 !== 1'b0 || wr3 !== 1'b0) begin
            errors++; $display("FAIL latency_idle: write %b/%b, expected 0", wr0, wr3);
        end
        @(posedge clk); #1;
        checks++;
        if (wr0 !== 1'b0 || wr3 !== 1'b0) begin
            errors++; $display("FAIL latency_load: write %b/%b, expected 0", wr0, wr3);
        end
        @(posedge clk); #1;
        checks++;
        if (wr0 !== 1'b1 || wr3 !== 1'b1) begin
            errors++; $display("FAIL latency_first: write %b/%b, expected 1", wr0, wr3);
        end
        drain("b4", 500);
        check_counts("b4", 200, 203);
    endtask

    task automatic test_sequence();
        clear_counts();
        allowed = 1'b1;
        send(2'd0, 10);
        send(2'd3, 5);
        send(2'd1, 10);
        drain("sequence", 200);
        check_counts("sequence", 25, 34);
        checks++;
        if (last0 - first0 + 1 != 27 || last3 - first3 + 1 != 36) begin
            errors++;
            $display("FAIL back_to_back span: dut0 %0d dut3 %0d cycles, expected 27 36",
                     last0 - first0 + 1, last3 - first3 + 1);
        end
    endtask

    task automatic test_stall();
        int i;
        clear_counts();
        allowed = 1'b1;
        send(2'd1, 130);
        i = 0;
        while ((q0.size() != 0 || q3.size() != 0 || busy0 || busy3) && i < 3000) begin
            @(posedge clk); #1;
            allowed = ((i % 3) == 0);
            i++;
        end
        allowed = 1'b1;
        drain("stall", 20);
        check_counts("stall", 130, 133);
    endtask

    task automatic test_full();
        clear_counts();
        allowed = 1'b0;
        send(2'd1, 5);
        send(2'd0, 0);
        send(2'd2, 4);
        send(2'd3, 2);
        send(2'd0, 3);
        note_valid = 1'b1; note_lane = 2'd2; note_dur = 16'd9;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b0 || rdy3 !== 1'b0) begin
            errors++; $display("FAIL full_ready: dut0 %b dut3 %b, expected 0", rdy0, rdy3);
        end
        @(posedge clk); #1 note_valid = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || busy3 !== 1'b1 || nwr0 != 0 || nwr3 != 0) begin
            errors++;
            $display("FAIL stalled_hold: busy %b/%b writes %0d/%0d, expected 1/1 0/0", busy0, busy3, nwr0, nwr3);
        end
        allowed = 1'b1;
        drain("full", 200);
        check_counts("full", 14, 29);
    endtask

    task automatic test_flush();
        clear_counts();
        allowed = 1'b1;
        send(2'd0, 100);
        send(2'd1, 20);
        send(2'd1, 20);
        send(2'd1, 20);
        repeat (3) begin @(posedge clk); #1; end
        flush = 1'b1; note_valid = 1'b1; note_lane = 2'd1; note_dur = 16'd7;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b0 || rdy3 !== 1'b0) begin
            errors++; $display("FAIL flush_ready: dut0 %b dut3 %b, expected 0", rdy0, rdy3);
        end
        @(posedge clk); #1;
        flush = 1'b0; note_valid = 1'b0;
        q0.delete(); q3.delete();
        checks++;
        if (busy0 !== 1'b0 || busy3 !== 1'b0 || wr0 !== 1'b0 || wr3 !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: busy %b/%b write %b/%b, expected 0", busy0, busy3, wr0, wr3);
        end
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (busy0 !== 1'b0 || busy3 !== 1'b0) begin
            errors++; $display("FAIL flush_dropped: busy %b/%b, expected 0", busy0, busy3);
        end
        send(2'd2, 3);
        drain("after_flush", 50);
    endtask

    task automatic test_reset_mid_play();
        clear_counts();
        allowed = 1'b1;
        send(2'd0, 50);
        repeat (10) begin @(posedge clk); #1; end
        resetn = 1'b0;
        #1;
        check_idle_outputs("reset_mid_play");
        q0.delete(); q3.delete();
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;
        send(2'd1, 4);
        drain("after_reset", 50);
    endtask

    initial begin
        test_reset();
        test_b4_tone();
        test_sequence();
        test_stall();
        test_full();
        test_flush();
        test_reset_mid_play();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Plays a queue of timed note events (lane F4/G4/B4 or rest, duration in audio samples) as square-wave samples into the Audio_Controller write port. Sits between the game/note logic and Audio_Controller, replacing free-running per-switch tone generation with a buffered, sample-accurate sequence. Pitch counts advance once per accepted audio sample, not per system clock, so pitch is independent of CLOCK_50.

## Interface
- DEPTH, 4: note FIFO entries (power of two, ≥2)
- DUR_W, 16: duration counter width (samples)
- GAP, 240: silent samples inserted after every note (0 = no gap)
- AMP, 32'h7F000000: positive square-wave level; negative level is two's-complement −AMP (32'h81000000)

- CLOCK_50  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous: discard queue and current note
- note_valid  in  1  note event offered
- note_ready  out  1  FIFO can accept (combinational: count<DEPTH && !flush)
- note_lane  in  2  0=F4, 1=G4, 2=B4, 3=rest
- note_dur  in  DUR_W  note length in samples
- audio_out_allowed  in  1  Audio_Controller output FIFO has space
- write_audio_out  out  1  sample write strobe
- left_channel_audio_out  out  32  sample data
- right_channel_audio_out  out  32  identical to left
- busy  out  1  state≠IDLE or FIFO non-empty

## Operation
- Push: note_valid && note_ready at an edge stores {lane, dur}. Full FIFO refuses even if a pop occurs the same cycle.
- FSM states IDLE, LOAD, PLAY, GAP.
  - IDLE: FIFO non-empty → LOAD; else stay.
  - LOAD (1 cycle): pop head; half_cnt←0, snd←0, dur_cnt←dur, half_lim←lane constant (F4 68, G4 61, B4 48, rest n/a). Next: PLAY if dur≠0; else GAP if GAP≠0; else IDLE.
  - PLAY: write_audio_out = audio_out_allowed. Each write: dur_cnt−1; if half_cnt==half_lim then half_cnt←0, snd toggles, else half_cnt+1. Write with dur_cnt==1 is the last: go GAP (gap_cnt←GAP) if GAP≠0, else IDLE.
  - GAP: write_audio_out = audio_out_allowed, data 0; gap_cnt−1 per write; last write (gap_cnt==1) → IDLE.
- Sample data: PLAY and lane≠3 → snd ? AMP : −AMP; rest lane, GAP, IDLE, LOAD → 0. Data is a registered function of current snd/state, valid whenever write_audio_out is high.
- Half-period = half_lim+1 samples; F4 period 138 samples ≈ 348 Hz at 48 kHz.
- No writes while audio_out_allowed low; all counters hold (stall is lossless).
- flush: next edge FIFO empty, state IDLE, snd 0; push same cycle dropped (note_ready low). flush beats pop.
- Reset (async, any state): FIFO empty, state IDLE, all counters 0, snd 0.

## Timing
- Reset values: note_ready 1, write_audio_out 0, both channels 32'h0, busy 0.
- Note accepted at edge t into empty FIFO in IDLE: LOAD during cycle t+1, PLAY from t+2; first write strobe earliest cycle t+2.
- Back-to-back notes with GAP=0: one LOAD cycle (no write) between last sample of one note and first of next.
- Exactly dur PLAY writes plus GAP silent writes per note; write_audio_out never high in IDLE or LOAD.
- busy is combinational from state and FIFO count.

## Structure
- Package tone_pkg: lane encoding constants (LANE_F4/G4/B4/REST), half-period constants 68/61/48, state enum, note struct {lane, dur}.
- One sub-module: note_fifo (DEPTH × (2+DUR_W), pointer+count, synchronous clear, async active-low reset). FSM, counters and sample mux in tone_sequencer.

## Test plan
- Reset mid-PLAY (resetn low 1 cycle) → immediately write_audio_out 0, channels 0, busy 0, note_ready 1.
- Push {B4, 200}, GAP=0, audio_out_allowed held 1 → first strobe 2 cycles after accept; 200 strobes; data −AMP for samples 1–49, AMP for 50–98, −AMP 99–147, AMP 148–196, −AMP 197–200; then IDLE.
- Push {F4,10},{rest,5},{G4,10} with GAP=3 → 10 tone, 3 zero, 5 zero, 3 zero, 10 tone, 3 zero writes; LOAD cycles between have no strobe.
- Toggle audio_out_allowed 1-of-3 cycles during {G4,130} → still exactly 130 writes, first toggle after sample 62, no sample lost or duplicated.
- Fill FIFO with 4 notes while stalled, offer 5th → note_ready 0, 5th not stored; {F4,0} entry → LOAD goes straight to GAP, zero tone samples.
- Assert flush during PLAY with 3 queued and note_valid high → next cycle IDLE, busy 0, no further strobes, offered note dropped.
